// File: rtl/stopwatch_timer.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_timer
// Description : Stopwatch / countdown timer (MM:SS.hh) driven by a divided
//               tick-enable from the system clock. Supports start, stop,
//               clear, lap capture, preload, up/down counting and BCD or
//               binary output encoding for the display decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter bit BCD_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        mode,
  input  logic        load_en,
  input  logic [23:0] load_val,
  output logic [23:0] time_out,
  output logic [23:0] lap_out,
  output logic        running,
  output logic        rollover,
  output logic        expired
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_nxt;
  logic             tick;

  // Time is kept in binary; encoding happens only on the output side.
  logic [6:0] min_q;
  logic [5:0] sec_q;
  logic [6:0] cs_q;
  logic [6:0] min_nxt;
  logic [5:0] sec_nxt;
  logic [6:0] cs_nxt;

  logic [6:0] min_step;
  logic [5:0] sec_step;
  logic [6:0] cs_step;
  logic       step_wrap;
  logic       step_zero;

  logic [6:0] min_ld;
  logic [5:0] sec_ld;
  logic [6:0] cs_ld;

  logic        dir_down;
  logic        dir_down_nxt;
  logic        rollover_nxt;
  logic        expired_nxt;
  logic        time_zero;
  logic        load_acc;
  logic        start_acc;
  logic [23:0] time_enc;
  logic [23:0] lap_nxt;

  // Two decimal digits from a binary value 0..99.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign tick      = (state == ST_RUN) && (div_cnt == DIV_LAST);
  assign time_zero = (min_q == 7'd0) && (sec_q == 6'd0) && (cs_q == 7'd0);

  // Preload only outside RUN, and never when clear is present.
  assign load_acc  = load_en && !clear && (state != ST_RUN);
  // stop only matters in RUN and start only outside RUN, so they never compete.
  assign start_acc = start && !clear && !load_acc && (state != ST_RUN);

  // Saturate out-of-range preload fields to their maximum.
  assign min_ld = (load_val[23:16] > 8'd99) ? 7'd99 : load_val[22:16];
  assign sec_ld = (load_val[15:8]  > 8'd59) ? 6'd59 : load_val[13:8];
  assign cs_ld  = (load_val[7:0]   > 8'd99) ? 7'd99 : load_val[6:0];

  // Single up or down step of the MM:SS.hh value with carry / borrow.
  always_comb begin
    min_step  = min_q;
    sec_step  = sec_q;
    cs_step   = cs_q;
    step_wrap = 1'b0;
    if (!dir_down) begin
      if (cs_q < 7'd99) begin
        cs_step = cs_q + 7'd1;
      end else begin
        cs_step = 7'd0;
        if (sec_q < 6'd59) begin
          sec_step = sec_q + 6'd1;
        end else begin
          sec_step = 6'd0;
          if (min_q < 7'd99) begin
            min_step = min_q + 7'd1;
          end else begin
            min_step  = 7'd0;
            step_wrap = 1'b1;
          end
        end
      end
    end else begin
      if (cs_q != 7'd0) begin
        cs_step = cs_q - 7'd1;
      end else begin
        cs_step = 7'd99;
        if (sec_q != 6'd0) begin
          sec_step = sec_q - 6'd1;
        end else begin
          sec_step = 6'd59;
          min_step = min_q - 7'd1;
        end
      end
    end
  end

  assign step_zero = dir_down && (min_step == 7'd0) && (sec_step == 6'd0) && (cs_step == 7'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: clear wins, expiry beats a coincident stop.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (tick && step_zero) state_nxt = ST_DONE;
          else if (stop)         state_nxt = ST_PAUSE;
        end
        default: begin
          // A down start at zero expires immediately without running.
          if (start_acc) state_nxt = (mode && time_zero) ? ST_DONE : ST_RUN;
        end
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    running = (state == ST_RUN);
  end

  // Next values for time, direction latch and the event pulses.
  always_comb begin
    min_nxt      = min_q;
    sec_nxt      = sec_q;
    cs_nxt       = cs_q;
    dir_down_nxt = dir_down;
    rollover_nxt = 1'b0;
    expired_nxt  = 1'b0;
    if (clear) begin
      min_nxt      = 7'd0;
      sec_nxt      = 6'd0;
      cs_nxt       = 7'd0;
      dir_down_nxt = 1'b0;
    end else if (load_acc) begin
      min_nxt = min_ld;
      sec_nxt = sec_ld;
      cs_nxt  = cs_ld;
    end else begin
      if (tick) begin
        min_nxt      = min_step;
        sec_nxt      = sec_step;
        cs_nxt       = cs_step;
        rollover_nxt = step_wrap;
        expired_nxt  = step_zero;
      end
      if (start_acc) begin
        dir_down_nxt = mode;
        expired_nxt  = mode && time_zero;
      end
    end
  end

  // Divider restarts from zero whenever RUN is entered or left.
  always_comb begin
    div_cnt_nxt = '0;
    if ((state == ST_RUN) && (state_nxt == ST_RUN) && !tick) begin
      div_cnt_nxt = div_cnt + 1'b1;
    end
  end

  // Lap capture takes the currently displayed value; clear zeroes it.
  always_comb begin
    lap_nxt = lap_out;
    if (clear)    lap_nxt = 24'd0;
    else if (lap) lap_nxt = time_enc;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      min_q    <= 7'd0;
      sec_q    <= 6'd0;
      cs_q     <= 7'd0;
      dir_down <= 1'b0;
      rollover <= 1'b0;
      expired  <= 1'b0;
      lap_out  <= 24'd0;
    end else begin
      div_cnt  <= div_cnt_nxt;
      min_q    <= min_nxt;
      sec_q    <= sec_nxt;
      cs_q     <= cs_nxt;
      dir_down <= dir_down_nxt;
      rollover <= rollover_nxt;
      expired  <= expired_nxt;
      lap_out  <= lap_nxt;
    end
  end

  generate
    if (BCD_OUT) begin : g_bcd
      assign time_enc = {to_bcd(min_q), to_bcd({1'b0, sec_q}), to_bcd(cs_q)};
    end else begin : g_bin
      assign time_enc = {1'b0, min_q, 2'b00, sec_q, 1'b0, cs_q};
    end
  endgenerate

  assign time_out = time_enc;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_timer
// Description : Directed scoreboard bench for stopwatch_timer (DIV = 10).
//               Two instances share stimulus: one BCD, one binary encoded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_timer;

  typedef struct {
    int    cyc;
    string name;
    int    m, s, c;
    int    lm, ls, lc;
    bit    run, ro, ex;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic        mode = 1'b0, load_en = 1'b0;
  logic [23:0] load_val = 24'd0;
  logic [23:0] t_bcd, l_bcd, t_bin, l_bin;
  logic        run_bcd, ro_bcd, ex_bcd, run_bin, ro_bin, ex_bin;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;

  stopwatch_timer #(.CLK_HZ(1000), .TICK_HZ(100), .BCD_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .mode(mode), .load_en(load_en), .load_val(load_val),
    .time_out(t_bcd), .lap_out(l_bcd), .running(run_bcd),
    .rollover(ro_bcd), .expired(ex_bcd)
  );

  stopwatch_timer #(.CLK_HZ(1000), .TICK_HZ(100), .BCD_OUT(1'b0)) dut_bin (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .mode(mode), .load_en(load_en), .load_val(load_val),
    .time_out(t_bin), .lap_out(l_bin), .running(run_bin),
    .rollover(ro_bin), .expired(ex_bin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd8(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [23:0] enc(input int m, input int s, input int c, input bit bcd);
    if (bcd) return {bcd8(m), bcd8(s), bcd8(c)};
    return {8'(m), 8'(s), 8'(c)};
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [23:0] act, input logic [23:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h (cycle %0d)", nm, fld, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: compares every expectation due at this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        e = q[i];
        q.delete(i);
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed", e.name, e.cyc);
        end else begin
          cmp(e.name, "time_bcd", t_bcd, enc(e.m, e.s, e.c, 1'b1));
          cmp(e.name, "time_bin", t_bin, enc(e.m, e.s, e.c, 1'b0));
          cmp(e.name, "lap_bcd",  l_bcd, enc(e.lm, e.ls, e.lc, 1'b1));
          cmp(e.name, "lap_bin",  l_bin, enc(e.lm, e.ls, e.lc, 1'b0));
          cmp(e.name, "running",  {22'd0, run_bin, run_bcd}, {22'd0, e.run, e.run});
          cmp(e.name, "rollover", {22'd0, ro_bin, ro_bcd},   {22'd0, e.ro, e.ro});
          cmp(e.name, "expired",  {22'd0, ex_bin, ex_bcd},   {22'd0, e.ex, e.ex});
        end
      end
    end
  end

  task automatic expect_at(input int c, input string nm, input int m, input int s, input int cs,
                           input int lm, input int ls, input int lc,
                           input bit run, input bit ro, input bit ex);
    exp_t x;
    x.cyc = c; x.name = nm;
    x.m = m; x.s = s; x.c = cs;
    x.lm = lm; x.ls = ls; x.lc = lc;
    x.run = run; x.ro = ro; x.ex = ex;
    q.push_back(x);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input bit md);
    mode = md; start = 1'b1;
    wait_clks(1);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    wait_clks(1);
    stop = 1'b0;
  endtask

  task automatic load(input logic [23:0] v);
    load_val = v; load_en = 1'b1;
    wait_clks(1);
    load_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    // Reset and basic up count.
    wait_clks(1);
    expect_at(cyc, "in_reset", 0,0,0, 0,0,0, 0,0,0);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(1);
    go(1'b0); b = cyc;
    expect_at(b,        "start_run",   0,0,0, 0,0,0, 1,0,0);
    expect_at(b + 9,    "pre_tick",    0,0,0, 0,0,0, 1,0,0);
    expect_at(b + 10,   "first_tick",  0,0,1, 0,0,0, 1,0,0);
    expect_at(b + 1000, "one_second",  0,1,0, 0,0,0, 1,0,0);
    wait_clks(1000);
    halt();
    expect_at(cyc, "stopped", 0,1,0, 0,0,0, 0,0,0);

    // Preload near the top and roll over.
    load(24'h63_3B_62);
    expect_at(cyc, "load_995998", 99,59,98, 0,0,0, 0,0,0);
    go(1'b0); b = cyc;
    expect_at(b + 10, "up_995999",     99,59,99, 0,0,0, 1,0,0);
    expect_at(b + 19, "pre_wrap",      99,59,99, 0,0,0, 1,0,0);
    expect_at(b + 20, "rollover",      0,0,0,    0,0,0, 1,1,0);
    expect_at(b + 21, "rollover_once", 0,0,0,    0,0,0, 1,0,0);

    // Lap coinciding with the tick that steps 05 -> 06.
    wait_clks(79);
    lap = 1'b1;
    wait_clks(1);
    lap = 1'b0;
    expect_at(cyc, "lap_on_tick", 0,0,6, 0,0,5, 1,0,0);
    halt();
    expect_at(cyc, "lap_stop", 0,0,6, 0,0,5, 0,0,0);
    wait_clks(50);
    expect_at(cyc, "frozen", 0,0,6, 0,0,5, 0,0,0);
    go(1'b0); b = cyc;
    expect_at(b + 9,  "resume_pre",  0,0,6, 0,0,5, 1,0,0);
    expect_at(b + 10, "resume_step", 0,0,7, 0,0,5, 1,0,0);
    wait_clks(10);

    // Preload ignored in RUN, saturated in PAUSE.
    load(24'hFF_FF_FF);
    expect_at(cyc, "load_in_run", 0,0,7, 0,0,5, 1,0,0);
    halt();
    expect_at(cyc, "pause_again", 0,0,7, 0,0,5, 0,0,0);
    load(24'hFF_FF_FF);
    expect_at(cyc, "load_saturate", 99,59,99, 0,0,5, 0,0,0);

    // Countdown to expiry.
    load(24'h00_01_00);
    expect_at(cyc, "load_000100", 0,1,0, 0,0,5, 0,0,0);
    go(1'b1); b = cyc;
    expect_at(b + 10,   "down_borrow", 0,0,99, 0,0,5, 1,0,0);
    expect_at(b + 999,  "down_last",   0,0,1,  0,0,5, 1,0,0);
    expect_at(b + 1000, "expired",     0,0,0,  0,0,5, 0,0,1);
    expect_at(b + 1001, "expired_once",0,0,0,  0,0,5, 0,0,0);
    wait_clks(1001);
    go(1'b1); b = cyc;
    expect_at(b,     "down_start_zero", 0,0,0, 0,0,5, 0,0,1);
    expect_at(b + 1, "stay_done",       0,0,0, 0,0,5, 0,0,0);
    wait_clks(1);

    // Minute borrow on countdown.
    load(24'h01_00_00);
    expect_at(cyc, "load_010000", 1,0,0, 0,0,5, 0,0,0);
    go(1'b1); b = cyc;
    expect_at(b + 10, "min_borrow", 0,59,99, 0,0,5, 1,0,0);
    wait_clks(10);

    // clear beats load and start in the same cycle.
    clear = 1'b1; load_en = 1'b1; load_val = 24'h05_05_05; start = 1'b1; mode = 1'b0;
    wait_clks(1);
    clear = 1'b0; load_en = 1'b0; start = 1'b0;
    expect_at(cyc, "clear_prio", 0,0,0, 0,0,0, 0,0,0);
    wait_clks(10);
    expect_at(cyc, "idle_after_clear", 0,0,0, 0,0,0, 0,0,0);

    // Asynchronous reset mid-run, then clean restart.
    go(1'b0); b = cyc;
    wait_clks(24);
    expect_at(cyc, "pre_reset", 0,0,2, 0,0,0, 1,0,0);
    wait_clks(1);
    rst_n = 1'b0;
    expect_at(cyc, "async_reset", 0,0,0, 0,0,0, 0,0,0);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(1);
    expect_at(cyc, "post_reset", 0,0,0, 0,0,0, 0,0,0);
    go(1'b0); b = cyc;
    expect_at(b + 9,  "restart_pre",  0,0,0, 0,0,0, 1,0,0);
    expect_at(b + 10, "restart_step", 0,0,1, 0,0,0, 1,0,0);
    wait_clks(12);

    wait_clks(3);
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never checked", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_timer.md
# stopwatch_timer

Parametrised stopwatch and countdown timer for the seven-segment clock display path. It keeps three packed fields: minutes 0–99, seconds 0–59 and hundredths 0–99. It runs from a single-clock tick-enable and never uses a derived clock. It adds start/stop/clear/lap/preload control, an up/down mode and selectable BCD or binary output encoding. Its outputs feed the existing display decoder directly.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz. DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- BCD_OUT, 1, output encoding. 1 = two BCD digits per byte. 0 = binary value per byte.
- clk  in  1  system clock. All state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle pulse: begin or resume counting.
- stop  in  1  single-cycle pulse: pause counting.
- clear  in  1  single-cycle pulse: zero the time and go to IDLE.
- lap  in  1  single-cycle pulse: capture the current time into lap_out.
- mode  in  1  direction. 0 = count up, 1 = count down. Sampled only when start is accepted.
- load_en  in  1  preload strobe. Ignored while in RUN.
- load_val  in  24  preload value: [23:16] min, [15:8] sec, [7:0] hundredths, always binary.
- time_out  out  24  current time as [23:16] min, [15:8] sec, [7:0] hundredths, encoded per BCD_OUT.
- lap_out  out  24  last captured lap time, same encoding as time_out.
- running  out  1  high while in RUN.
- rollover  out  1  one-cycle pulse when up-count wraps 99:59:99 → 00:00:00.
- expired  out  1  one-cycle pulse when down-count reaches 00:00:00.

## Operation
- Tick generator:
  - div_cnt counts 0..DIV-1 only while in RUN.
  - tick is asserted for one clk when div_cnt = DIV-1.
  - div_cnt is forced to 0 in every non-RUN state, so the first tick comes DIV clks after start is accepted.
- The time is held internally as three binary fields (min 7b, sec 6b, cs 7b). The output encoder converts each field to two BCD digits when BCD_OUT=1.
- Up step on tick:
  - cs < 99: cs+1.
  - Otherwise cs=0, then sec < 59: sec+1.
  - Otherwise sec=0, then min < 99: min+1.
  - Otherwise all fields become 0 and rollover pulses. The counter stays in RUN.
- Down step on tick:
  - cs > 0: cs−1.
  - Otherwise cs=99, then sec > 0: sec−1.
  - Otherwise sec=59 and min−1.
  - A step that lands on 00:00:00 moves to DONE and pulses expired.
- States:
  - IDLE: start → RUN.
  - RUN: stop → PAUSE; down-count reaching zero → DONE.
  - PAUSE: start → RUN.
  - DONE: start → RUN if the time is non-zero or the latched mode is up.
  - Any state: clear → IDLE.
- Down start at zero: a start accepted with mode=1 and time = 00:00:00 goes straight to DONE and pulses expired in the next cycle. No tick occurs.
- Control priority in one cycle: clear > load_en > stop > start. Lower-priority inputs are ignored in that cycle.
- load_en is accepted in IDLE, PAUSE and DONE, and leaves the state unchanged.
  - Out-of-range fields saturate: min > 99 → 99, sec > 59 → 59, cs > 99 → 99.
- lap is independent of state and priority except clear, which also zeroes lap_out. lap_out takes the time_out value present in the cycle lap is high, i.e. the pre-tick value if a tick coincides.
- stop coinciding with tick: the tick step is applied, then the counter pauses.
- start in RUN and stop outside RUN are ignored.

## Timing
- Reset values: time 00:00:00, lap_out 0, running 0, rollover 0, expired 0, state IDLE, div_cnt 0.
- Latencies, all outputs registered:
  - time_out updates one clk after the tick cycle.
  - running rises one clk after start and falls one clk after stop, clear or expiry.
  - rollover and expired pulse in the same cycle time_out shows 00:00:00.
- Load and lap: load takes effect on time_out one clk after load_en. lap_out updates one clk after lap.
- Reset mid-count: immediately returns all state to the reset values. There is no partial tick after release.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset, then start; run 1000 clks → time_out=24'h000100 (BCD 00:01.00), running=1, no rollover.
- load_val=24'h63_3B_62 (99:59:98), start, mode=0; after 20 clks → time_out=0, rollover one-cycle pulse, running stays 1.
- load_val=24'h00_01_00, start with mode=1; after 1000 clks → time_out=0, expired pulse, running=0, state DONE. A further start leaves the state in DONE with a new expired pulse.
- Running at 00:00.05 with lap and a tick in the same cycle → lap_out=24'h000005 and time_out=24'h000006. Then stop, wait 50 clks → time_out frozen. Then start → resumes, first step 10 clks later.
- load_val=24'hFF_FF_FF in PAUSE → time_out=24'h995999 (BCD_OUT=1) or 24'h633B63 (BCD_OUT=0). load_en during RUN → ignored.
- clear, load_en and start in the same cycle → IDLE, time 0, lap_out 0. Assert rst_n low mid-RUN → all outputs 0 asynchronously.
